// File: rtl/rr_select.sv
// -----------------------------------------------------------------------------
// rr_select -- combinational round-robin priority picker.
//
// Scans the request vector starting at last_idx+1 and wrapping from PORTS-1
// back to 0; the first asserted request wins.
//
// Ports
//   req       [PORTS-1:0]  request vector, one bit per master
//   last_idx  [IW-1:0]     index of the most recent winner (lowest priority)
//   valid                  at least one request is asserted
//   idx       [IW-1:0]     index of the winning request (0 when !valid)
// -----------------------------------------------------------------------------
module rr_select #(
  parameter int PORTS = 4,
  parameter int IW    = 2
) (
  input  logic [PORTS-1:0] req,
  input  logic [IW-1:0]    last_idx,
  output logic             valid,
  output logic [IW-1:0]    idx
);

  // (base + k) modulo PORTS, where k ranges 1..PORTS.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
    int sum;
    sum = (int'(base) + k) % PORTS;
    return IW'(sum);
  endfunction

  // Walk from the lowest priority candidate (k=PORTS, i.e. last_idx itself)
  // up to the highest (k=1); the last hit in the walk is the winner.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    valid = 1'b0;
    idx   = '0;
    for (int k = PORTS; k >= 1; k--) begin
      if (req[wrap_add(last_idx, k)]) begin
        valid = 1'b1;
        idx   = wrap_add(last_idx, k);
      end
    end
  end

endmodule

// File: rtl/mm_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mm_rr_arbiter -- round-robin arbiter sharing one memory-mapped slave port
// between PORTS masters.
//
// In IDLE the winner is picked combinationally and forwarded in the same
// cycle. If the slave stalls, the winner is locked and forwarded until the
// slave accepts; only then does the round-robin pointer advance.
//
// Ports
//   clk                              rising-edge clock
//   reset                            asynchronous active-high reset
//   s_addr  [PORTS-1:0][AWIDTH-1:0]  per-master address
//   s_wreq  [PORTS-1:0]              per-master write request
//   s_wdat  [PORTS-1:0][DWIDTH-1:0]  per-master write data
//   s_rreq  [PORTS-1:0]              per-master read request
//   s_rdat  [PORTS-1:0][DWIDTH-1:0]  per-master read data (copy of m_rdat)
//   s_busy  [PORTS-1:0]              per-master stall
//   m_addr  [AWIDTH-1:0]             shared address
//   m_wreq                           shared write request
//   m_wdat  [DWIDTH-1:0]             shared write data
//   m_rreq                           shared read request
//   m_rdat  [DWIDTH-1:0]             shared read data
//   m_busy                           shared stall from the slave
// -----------------------------------------------------------------------------
module mm_rr_arbiter #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 8,
  parameter int PORTS  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [PORTS-1:0][AWIDTH-1:0] s_addr,
  input  logic [PORTS-1:0]             s_wreq,
  input  logic [PORTS-1:0][DWIDTH-1:0] s_wdat,
  input  logic [PORTS-1:0]             s_rreq,
  output logic [PORTS-1:0][DWIDTH-1:0] s_rdat,
  output logic [PORTS-1:0]             s_busy,
  output logic [AWIDTH-1:0]            m_addr,
  output logic                         m_wreq,
  output logic [DWIDTH-1:0]            m_wdat,
  output logic                         m_rreq,
  input  logic [DWIDTH-1:0]            m_rdat,
  input  logic                         m_busy
);

  localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e        state_q,    state_d;
  logic [IW-1:0] lck_idx_q,  lck_idx_d;
  logic [IW-1:0] last_idx_q, last_idx_d;

  logic          sel_valid;
  logic [IW-1:0] sel_idx;
  logic          gnt_valid;
  logic [IW-1:0] gnt_idx;

  rr_select #(
    .PORTS (PORTS),
    .IW    (IW)
  ) u_rr_select (
    .req      (s_wreq | s_rreq),
    .last_idx (last_idx_q),
    .valid    (sel_valid),
    .idx      (sel_idx)
  );

  // The locked port is forwarded unconditionally; with a single port the
  // arbiter degenerates into a wire, so the lone port is always granted.
  always_comb begin
    gnt_valid = (PORTS == 1) || (state_q == ST_LOCKED) || sel_valid;
    gnt_idx   = (state_q == ST_LOCKED) ? lck_idx_q : sel_idx;
  end

  // Shared-side mux; requests are masked while reset is high so an abandoned
  // transaction disappears from the slave immediately.
  always_comb begin
    m_addr = '0;
    m_wdat = '0;
    m_wreq = 1'b0;
    m_rreq = 1'b0;
    if (gnt_valid) begin
      m_addr = s_addr[gnt_idx];
      m_wdat = s_wdat[gnt_idx];
      m_wreq = s_wreq[gnt_idx] & ~reset;
      m_rreq = s_rreq[gnt_idx] & ~reset;
    end
  end

  // Only the granted port sees the slave's stall; everyone else is held off.
  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      s_rdat[i] = m_rdat;
      s_busy[i] = 1'b1;
      if (!reset && gnt_valid && (gnt_idx == IW'(i))) begin
        s_busy[i] = m_busy;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    lck_idx_d  = lck_idx_q;
    last_idx_d = last_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          if (m_busy) begin
            state_d   = ST_LOCKED;
            lck_idx_d = sel_idx;
          end else begin
            last_idx_d = sel_idx;
          end
        end
      end
      ST_LOCKED: begin
        if (!m_busy) begin
          state_d    = ST_IDLE;
          last_idx_d = lck_idx_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pointer resets to PORTS-1 so port 0 has first priority after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      lck_idx_q  <= '0;
      last_idx_q <= IW'(PORTS - 1);
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      lck_idx_q  <= lck_idx_d;
      last_idx_q <= last_idx_d;
    end
  end

endmodule

// File: tb/tb_mm_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mm_rr_arbiter -- directed vectors for mm_rr_arbiter (PORTS=4, 8-bit
// address/data), followed by a random-traffic phase checked for fairness,
// one-hot grants and stability under slave stall.
// -----------------------------------------------------------------------------
module tb_mm_rr_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int NP = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NP-1:0][AW-1:0] s_addr;
  logic [NP-1:0]        s_wreq;
  logic [NP-1:0][DW-1:0] s_wdat;
  logic [NP-1:0]        s_rreq;
  logic [NP-1:0][DW-1:0] s_rdat;
  logic [NP-1:0]        s_busy;
  logic [AW-1:0]        m_addr;
  logic                 m_wreq;
  logic [DW-1:0]        m_wdat;
  logic                 m_rreq;
  logic [DW-1:0]        m_rdat;
  logic                 m_busy;

  int n_cmp = 0;
  int n_err = 0;

  mm_rr_arbiter #(
    .AWIDTH (AW),
    .DWIDTH (DW),
    .PORTS  (NP)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .s_addr (s_addr),
    .s_wreq (s_wreq),
    .s_wdat (s_wdat),
    .s_rreq (s_rreq),
    .s_rdat (s_rdat),
    .s_busy (s_busy),
    .m_addr (m_addr),
    .m_wreq (m_wreq),
    .m_wdat (m_wdat),
    .m_rreq (m_rreq),
    .m_rdat (m_rdat),
    .m_busy (m_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // 3 units later, well clear of both clock edges.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic default_addrs();
    for (int i = 0; i < NP; i++) begin
      s_addr[i] = 8'h10 + 8'(i);
      s_wdat[i] = 8'hC0 + 8'(i);
    end
  endtask

  // Random-phase bookkeeping
  int   wait_cnt [NP];
  logic [NP-1:0] comp;
  logic prev_hold;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_wdat;
  logic prev_wreq, prev_rreq;

  initial begin
    reset  = 1'b1;
    s_wreq = '0;
    s_rreq = '0;
    m_rdat = '0;
    m_busy = 1'b0;
    default_addrs();

    // ---- reset gating: a request during reset must not reach the slave
    s_rreq = 4'b0001;
    next_cycle();
    settle();
    check("rst_m_rreq", 32'(m_rreq), 32'd0);
    check("rst_m_wreq", 32'(m_wreq), 32'd0);
    check("rst_s_busy", 32'(s_busy), 32'hF);

    // ---- ports 0 and 2 read, slave ready: 0, 2, 0
    next_cycle();
    reset  = 1'b0;
    s_rreq = 4'b0101;
    settle();
    check("rr_c1_busy", 32'(s_busy), 32'hE);
    check("rr_c1_addr", 32'(m_addr), 32'h10);
    check("rr_c1_rreq", 32'(m_rreq), 32'd1);
    next_cycle();
    settle();
    check("rr_c2_busy", 32'(s_busy), 32'hB);
    check("rr_c2_addr", 32'(m_addr), 32'h12);
    next_cycle();
    settle();
    check("rr_c3_busy", 32'(s_busy), 32'hE);

    // ---- idle: shared side all zero
    next_cycle();
    s_rreq = '0;
    settle();
    check("idle_addr", 32'(m_addr), 32'h0);
    check("idle_wdat", 32'(m_wdat), 32'h0);
    check("idle_req",  32'({m_wreq, m_rreq}), 32'h0);

    // ---- port 1 write stalled 3 cycles, port 3 joins in cycle 2
    next_cycle();
    s_addr[1] = 8'h3C;
    s_wdat[1] = 8'hA5;
    s_wreq    = 4'b0010;
    m_busy    = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) s_rreq = 4'b1000;
      if (c == 4) m_busy = 1'b0;
      settle();
      check($sformatf("lock_c%0d_addr", c), 32'(m_addr), 32'h3C);
      check($sformatf("lock_c%0d_wdat", c), 32'(m_wdat), 32'hA5);
      check($sformatf("lock_c%0d_wreq", c), 32'(m_wreq), 32'd1);
      check($sformatf("lock_c%0d_busy", c), 32'(s_busy), (c == 4) ? 32'hD : 32'hF);
      next_cycle();
    end
    s_wreq = '0;
    default_addrs();
    settle();
    check("lock_c5_busy", 32'(s_busy), 32'h7);
    check("lock_c5_addr", 32'(m_addr), 32'h13);

    // ---- all four request continuously: 0,1,2,3,0,1,2,3
    next_cycle();
    s_rreq = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      settle();
      check($sformatf("all_c%0d_busy", c), 32'(s_busy), 32'(~(4'b0001 << (c % 4)) & 4'hF));
      check($sformatf("all_c%0d_addr", c), 32'(m_addr), 32'h10 + 32'(c % 4));
      next_cycle();
    end

    // ---- port 2 read returns data in the completion cycle
    s_rreq = 4'b0100;
    m_rdat = 8'h5A;
    settle();
    check("rd_s_rdat2", 32'(s_rdat[2]), 32'h5A);
    check("rd_s_busy",  32'(s_busy), 32'hB);

    // ---- back-to-back: port 1 alone twice, then loses to port 3
    next_cycle();
    m_rdat = 8'h00;
    s_rreq = 4'b0010;
    settle();
    check("b2b_c1_busy", 32'(s_busy), 32'hD);
    next_cycle();
    settle();
    check("b2b_c2_busy", 32'(s_busy), 32'hD);
    next_cycle();
    s_rreq = 4'b1010;
    settle();
    check("b2b_c3_busy", 32'(s_busy), 32'h7);

    // ---- port 0 with write and read together is forwarded as-is
    next_cycle();
    s_rreq = 4'b0001;
    s_wreq = 4'b0001;
    settle();
    check("wr_rd_req",  32'({m_wreq, m_rreq}), 32'h3);
    check("wr_rd_wdat", 32'(m_wdat), 32'hC0);

    // ---- lock on port 3, then reset in the middle of it
    next_cycle();
    s_wreq = '0;
    s_rreq = 4'b1000;
    m_busy = 1'b1;
    settle();
    check("rl_c1_addr", 32'(m_addr), 32'h13);
    next_cycle();
    s_rreq = 4'b1011;   // port 1 would win a re-arbitration from last_idx=0
    settle();
    check("rl_c2_addr", 32'(m_addr), 32'h13);
    check("rl_c2_busy", 32'(s_busy), 32'hF);
    reset = 1'b1;
    #1;
    check("rl_rst_req",  32'({m_wreq, m_rreq}), 32'h0);
    check("rl_rst_busy", 32'(s_busy), 32'hF);
    next_cycle();
    reset  = 1'b0;
    m_busy = 1'b0;
    s_rreq = 4'b1001;
    settle();
    check("rl_post_busy", 32'(s_busy), 32'hE);
    check("rl_post_addr", 32'(m_addr), 32'h10);

    // ---- random concurrent traffic
    next_cycle();
    s_rreq = '0;
    s_wreq = '0;
    for (int i = 0; i < NP; i++) wait_cnt[i] = 0;
    comp      = '0;
    prev_hold = 1'b0;
    prev_addr = '0;
    prev_wdat = '0;
    prev_wreq = 1'b0;
    prev_rreq = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NP; i++) begin
        if (comp[i] || !(s_wreq[i] || s_rreq[i])) begin
          s_wreq[i] = 1'b0;
          s_rreq[i] = 1'b0;
          if ($urandom_range(2) != 0) begin
            s_addr[i] = 8'($urandom);
            s_wdat[i] = 8'($urandom);
            if ($urandom_range(1) == 1) s_wreq[i] = 1'b1;
            else                        s_rreq[i] = 1'b1;
          end
        end
      end
      m_busy = ($urandom_range(1) == 1);
      m_rdat = 8'($urandom);
      settle();

      if (prev_hold) begin
        check("rnd_hold", 32'({m_addr, m_wdat, m_wreq, m_rreq}),
              32'({prev_addr, prev_wdat, prev_wreq, prev_rreq}));
      end

      comp = (s_wreq | s_rreq) & ~s_busy;
      check("rnd_onehot", 32'($countones(~s_busy) <= 1), 32'd1);
      for (int i = 0; i < NP; i++) begin
        if (comp[i]) begin
          check($sformatf("rnd_starve_p%0d", i), 32'(wait_cnt[i] <= NP - 1), 32'd1);
          wait_cnt[i] = 0;
        end else if ((s_wreq[i] || s_rreq[i]) && (comp != '0)) begin
          wait_cnt[i]++;
        end else if (!(s_wreq[i] || s_rreq[i])) begin
          wait_cnt[i] = 0;
        end
      end

      prev_hold = (m_wreq | m_rreq) & m_busy;
      prev_addr = m_addr;
      prev_wdat = m_wdat;
      prev_wreq = m_wreq;
      prev_rreq = m_rreq;
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
